// File: rtl/vx_gpu_pkg.sv
// Shared LSU block-scheduler widths, defaults and request record.
// The scheduler and its per-block sub-module both import this package.
package vx_gpu_pkg;

   localparam int LSU_SCHED_ISSUE_WIDTH = 4;
   localparam int LSU_SCHED_NUM_BLOCKS  = 2;
   localparam int LSU_SCHED_NUM_WARPS   = 16;
   localparam int LSU_SCHED_MAX_PENDING = 4;
   localparam int LSU_SCHED_DATA_W      = 64;

   // Slot index width inside one block; never narrower than one bit.
   function automatic int lsu_sched_slot_w(input int iw, input int nb);
      return ($clog2(iw / nb) < 1) ? 1 : $clog2(iw / nb);
   endfunction

   localparam int LSU_SCHED_WID_W  = $clog2(LSU_SCHED_NUM_WARPS);
   localparam int LSU_SCHED_SLOT_W = lsu_sched_slot_w(LSU_SCHED_ISSUE_WIDTH, LSU_SCHED_NUM_BLOCKS);
   localparam int LSU_SCHED_CNT_W  = $clog2(LSU_SCHED_MAX_PENDING + 1);

   typedef struct packed {
      logic [LSU_SCHED_DATA_W-1:0] data;
      logic [LSU_SCHED_WID_W-1:0]  wid;
      logic                        is_amo;
      logic [LSU_SCHED_SLOT_W-1:0] slot;
   } lsu_sched_req_t;

endpackage

// File: rtl/vx_lsu_sched_block.sv
// One LSU block: round-robin pick among its slots, credit counter and a
// single output register. Handshake: a transfer happens when valid && ready.
module vx_lsu_sched_block
   import vx_gpu_pkg::*;
#(
   parameter int NUM_REQS    = LSU_SCHED_ISSUE_WIDTH / LSU_SCHED_NUM_BLOCKS,
   parameter int DATA_W      = LSU_SCHED_DATA_W,
   parameter int WID_W       = LSU_SCHED_WID_W,
   parameter int SLOT_W      = LSU_SCHED_SLOT_W,
   parameter int MAX_PENDING = LSU_SCHED_MAX_PENDING,
   parameter int CNT_W       = LSU_SCHED_CNT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQS-1:0]        req_valid,
   input  logic [NUM_REQS*DATA_W-1:0] req_data,
   input  logic [NUM_REQS*WID_W-1:0]  req_wid,
   input  logic [NUM_REQS-1:0]        req_is_amo,
   output logic [NUM_REQS-1:0]        req_ready,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [WID_W-1:0]           out_wid,
   output logic                       out_is_amo,
   output logic [SLOT_W-1:0]          out_slot,
   input  logic                       out_ready,
   input  logic                       rsp_valid,
   output logic                       pending
);

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [WID_W-1:0]  out_wid_q, out_wid_d;
   logic              out_is_amo_q, out_is_amo_d;
   logic [SLOT_W-1:0] out_slot_q, out_slot_d;
   logic [SLOT_W-1:0] ptr_q, ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              found;
   logic              accept;
   logic              rsp_ok;
   logic [SLOT_W-1:0] win;

   always_comb begin
      found = 1'b0;
      win   = '0;
      // First pass covers slots at or after the pointer, second pass wraps.
      for (int i = 0; i < NUM_REQS; i++) begin
         if (!found && req_valid[i] && (SLOT_W'(i) >= ptr_q)) begin
            found = 1'b1;
            win   = SLOT_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQS; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            win   = SLOT_W'(i);
         end
      end

      accept = found && (!out_valid_q || out_ready) && (cnt_q < CNT_W'(MAX_PENDING));
      rsp_ok = rsp_valid && (cnt_q != '0);

      req_ready    = '0;
      out_valid_d  = out_valid_q && !out_ready;
      out_data_d   = out_data_q;
      out_wid_d    = out_wid_q;
      out_is_amo_d = out_is_amo_q;
      out_slot_d   = out_slot_q;
      ptr_d        = ptr_q;
      for (int i = 0; i < NUM_REQS; i++) begin
         if (accept && (SLOT_W'(i) == win)) begin
            req_ready[i] = 1'b1;
            out_valid_d  = 1'b1;
            out_data_d   = req_data[i*DATA_W +: DATA_W];
            out_wid_d    = req_wid[i*WID_W +: WID_W];
            out_is_amo_d = req_is_amo[i];
            out_slot_d   = win;
         end
      end
      if (accept) begin
         ptr_d = (win == SLOT_W'(NUM_REQS - 1)) ? '0 : win + 1'b1;
      end

      // A response with no credit outstanding is ignored so the count never wraps.
      cnt_d = cnt_q;
      if (accept && !rsp_ok) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!accept && rsp_ok) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_wid_q    <= '0;
         out_is_amo_q <= 1'b0;
         out_slot_q   <= '0;
         ptr_q        <= '0;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_wid_q    <= out_wid_d;
         out_is_amo_q <= out_is_amo_d;
         out_slot_q   <= out_slot_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
      end
   end

   always @(posedge clk) begin
      if (reset && rsp_valid) begin
         assert (cnt_q != '0);
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_wid    = out_wid_q;
   assign out_is_amo = out_is_amo_q;
   assign out_slot   = out_slot_q;
   assign pending    = out_valid_q || (cnt_q != '0);

endmodule

// File: rtl/vx_lsu_block_scheduler.sv
// Fans issue slots out to LSU blocks (slot i -> block i % NUM_BLOCKS) and
// keeps a per-warp fence that holds a warp back while its AMO is in flight.
module vx_lsu_block_scheduler
   import vx_gpu_pkg::*;
#(
   parameter int  ISSUE_WIDTH = LSU_SCHED_ISSUE_WIDTH,
   parameter int  NUM_BLOCKS  = LSU_SCHED_NUM_BLOCKS,
   parameter int  NUM_WARPS   = LSU_SCHED_NUM_WARPS,
   parameter int  MAX_PENDING = LSU_SCHED_MAX_PENDING,
   parameter int  DATA_W      = LSU_SCHED_DATA_W,
   localparam int WID_W       = $clog2(NUM_WARPS),
   localparam int SLOT_W      = lsu_sched_slot_w(ISSUE_WIDTH, NUM_BLOCKS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [ISSUE_WIDTH-1:0]        in_valid,
   input  logic [ISSUE_WIDTH*DATA_W-1:0] in_data,
   input  logic [ISSUE_WIDTH*WID_W-1:0]  in_wid,
   input  logic [ISSUE_WIDTH-1:0]        in_is_amo,
   output logic [ISSUE_WIDTH-1:0]        in_ready,
   output logic [NUM_BLOCKS-1:0]         out_valid,
   output logic [NUM_BLOCKS*DATA_W-1:0]  out_data,
   output logic [NUM_BLOCKS*WID_W-1:0]   out_wid,
   output logic [NUM_BLOCKS-1:0]         out_is_amo,
   output logic [NUM_BLOCKS*SLOT_W-1:0]  out_slot,
   input  logic [NUM_BLOCKS-1:0]         out_ready,
   input  logic [NUM_BLOCKS-1:0]         rsp_valid,
   input  logic [NUM_BLOCKS-1:0]         rsp_is_amo,
   input  logic [NUM_BLOCKS*WID_W-1:0]   rsp_wid,
   output logic                          busy
);

   localparam int SPB   = ISSUE_WIDTH / NUM_BLOCKS;
   localparam int CNT_W = $clog2(MAX_PENDING + 1);

   logic [NUM_WARPS-1:0]   fence_q, fence_d;
   logic [ISSUE_WIDTH-1:0] slot_eligible;
   logic [NUM_BLOCKS-1:0]  blk_pending;

   // Reset gating keeps in_ready low while reset is held.
   for (genvar s = 0; s < ISSUE_WIDTH; s++) begin : g_slot
      assign slot_eligible[s] = reset && in_valid[s] && !fence_q[in_wid[s*WID_W +: WID_W]];
   end

   for (genvar b = 0; b < NUM_BLOCKS; b++) begin : g_blk
      logic [SPB-1:0]        bv;
      logic [SPB-1:0]        br;
      logic [SPB-1:0]        ba;
      logic [SPB*DATA_W-1:0] bd;
      logic [SPB*WID_W-1:0]  bw;

      for (genvar j = 0; j < SPB; j++) begin : g_map
         localparam int S = j * NUM_BLOCKS + b;
         assign bv[j]                   = slot_eligible[S];
         assign ba[j]                   = in_is_amo[S];
         assign bd[j*DATA_W +: DATA_W]  = in_data[S*DATA_W +: DATA_W];
         assign bw[j*WID_W +: WID_W]    = in_wid[S*WID_W +: WID_W];
         assign in_ready[S]             = br[j];
      end

      vx_lsu_sched_block #(
         .NUM_REQS    (SPB),
         .DATA_W      (DATA_W),
         .WID_W       (WID_W),
         .SLOT_W      (SLOT_W),
         .MAX_PENDING (MAX_PENDING),
         .CNT_W       (CNT_W)
      ) u_block (
         .clk        (clk),
         .reset      (reset),
         .req_valid  (bv),
         .req_data   (bd),
         .req_wid    (bw),
         .req_is_amo (ba),
         .req_ready  (br),
         .out_valid  (out_valid[b]),
         .out_data   (out_data[b*DATA_W +: DATA_W]),
         .out_wid    (out_wid[b*WID_W +: WID_W]),
         .out_is_amo (out_is_amo[b]),
         .out_slot   (out_slot[b*SLOT_W +: SLOT_W]),
         .out_ready  (out_ready[b]),
         .rsp_valid  (rsp_valid[b]),
         .pending    (blk_pending[b])
      );
   end

   // Clears are applied before sets so an AMO accepted in the same cycle wins.
   always_comb begin
      fence_d = fence_q;
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         if (rsp_valid[b] && rsp_is_amo[b]) begin
            fence_d[rsp_wid[b*WID_W +: WID_W]] = 1'b0;
         end
      end
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
         if (in_ready[s] && in_is_amo[s]) begin
            fence_d[in_wid[s*WID_W +: WID_W]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fence_q <= '0;
      end else begin
         fence_q <= fence_d;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < ISSUE_WIDTH; s++) begin
            if (in_valid[s]) begin
               assert ((int'(in_wid[s*WID_W +: WID_W]) % ISSUE_WIDTH) == s);
            end
         end
      end
   end

   assign busy = |blk_pending;

endmodule
